// File: rtl/typed_skid_stage.sv
// Two-entry valid/ready skid buffer for a packed array of DTYPE elements; in_ready is registered.
// Optional TYPED_SKID_STAGE_XFER_CNT_EN adds a 16-bit wrapping count of downstream transfers.
module typed_skid_stage #(
    parameter int  width = 1,
    parameter type DTYPE = logic
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  DTYPE [width-1:0]       d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output DTYPE [width-1:0]       q
`ifdef TYPED_SKID_STAGE_XFER_CNT_EN
    ,
    output logic [15:0]            xfer_cnt
`endif
);

    // Encoding is {main_v, skid_v}, so 2'b01 is the unreachable skid-without-main case.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    DTYPE [width-1:0] main_q, main_d;
    DTYPE [width-1:0] skid_q, skid_d;

    logic main_v;
    logic skid_v;
    logic in_fire;
    logic out_fire;

    assign main_v    = state_q[1];
    assign skid_v    = state_q[0];
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign q         = main_q;
    assign in_fire   = in_valid & ~skid_v;
    assign out_fire  = main_v & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = d;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = d;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = d;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef TYPED_SKID_STAGE_XFER_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

    a_no_skid_without_main: assert property (@(posedge clk) disable iff (!rst_n) !(skid_v && !main_v));

endmodule

// File: tb/tb_typed_skid_stage.sv
// Randomized and directed bench for typed_skid_stage checked against an occupancy-queue model.
module tb_typed_skid_stage;

    typedef struct packed {
        logic [3:0] x;
        logic [1:5] y;
    } s_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [3:0][3:0]  d = '0;
    logic             in_ready;
    logic             out_valid;
    logic [3:0][3:0]  q;

    logic             s_in_valid = 1'b0;
    logic             s_out_ready = 1'b1;
    s_t [1:0]         sd = '0;
    logic             s_in_ready;
    logic             s_out_valid;
    s_t [1:0]         sq;

`ifdef TYPED_SKID_STAGE_XFER_CNT_EN
    logic [15:0]      xfer_cnt;
    logic [15:0]      s_xfer_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    typed_skid_stage #(.width(4), .DTYPE(logic [3:0])) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q)
`ifdef TYPED_SKID_STAGE_XFER_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    typed_skid_stage #(.width(2), .DTYPE(s_t)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .d(sd),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .q(sq)
`ifdef TYPED_SKID_STAGE_XFER_CNT_EN
        , .xfer_cnt(s_xfer_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a FIFO of at most two beats.
    logic [15:0] mq[$];
    logic [15:0] mcnt = 16'd0;
    logic [15:0] popped;
    bit          model_live = 1'b0;
    bit          m_in_fire;
    bit          m_out_fire;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mcnt       = 16'd0;
            model_live = 1'b1;
        end else if (model_live) begin
            m_in_fire  = in_valid && (mq.size() < 2);
            m_out_fire = out_ready && (mq.size() > 0);
            if (m_out_fire) begin
                popped = mq.pop_front();
                mcnt   = mcnt + 16'd1;
                if (mcnt < 16'd2000) $display("[TB] out beat %h", popped);
            end
            if (m_in_fire) mq.push_back(d);
        end
    end

    always @(negedge clk) begin
        if (model_live && rst_n) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            if (mq.size() > 0) check("q", {16'd0, q}, {16'd0, mq[0]});
`ifdef TYPED_SKID_STAGE_XFER_CNT_EN
            check("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, mcnt});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] sv;

    initial begin
        // Reset state
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_q", {16'd0, q}, 32'd0);
        rst_n = 1'b1;

        // Single beat latency
        d = 16'hA5C3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_q", {16'd0, q}, 32'h0000A5C3);
        in_valid = 1'b0;
        tick();
        check("t1_empty", {31'd0, out_valid}, 32'd0);

        // Streaming at full throughput
        for (int i = 1; i <= 8; i++) begin
            d = 16'(i); in_valid = 1'b1;
            tick();
            check("t2_q", {16'd0, q}, 32'(i));
            check("t2_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("t2_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure fills the skid entry
        out_ready = 1'b0;
        d = 16'h1111; in_valid = 1'b1;
        tick();
        check("t3_q1", {16'd0, q}, 32'h00001111);
        d = 16'h2222;
        tick();
        check("t3_full", {31'd0, in_ready}, 32'd0);
        check("t3_hold", {16'd0, q}, 32'h00001111);
        d = 16'h3333;
        tick();
        check("t3_ignored_hold", {16'd0, q}, 32'h00001111);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("t3_q2", {16'd0, q}, 32'h00002222);
        check("t3_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        check("t3_drained", {31'd0, out_valid}, 32'd0);

        // Reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; d = 16'hAAAA;
        tick();
        d = 16'hBBBB;
        tick();
        check("t4_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("t4_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t4_rst_ready", {31'd0, in_ready}, 32'd1);
        check("t4_rst_q", {16'd0, q}, 32'd0);
        rst_n = 1'b1; d = 16'hBEEF; out_ready = 1'b1;
        tick();
        check("t4_beef", {16'd0, q}, 32'h0000BEEF);
        in_valid = 1'b0;
        tick();
        check("t4_alone", {31'd0, out_valid}, 32'd0);

        // Struct element type passes bits untouched
        sd = {9'h1F3, 9'h0AA}; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        sv = sq;
        check("t5_valid", {31'd0, s_out_valid}, 32'd1);
        check("t5_q", {14'd0, sv}, {14'd0, 9'h1F3, 9'h0AA});
        check("t5_inv", {14'd0, ~sv}, {14'd0, 9'h00C, 9'h155});

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            d         = 16'($urandom);
            rst_n     = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst_n = 1'b1;

`ifdef TYPED_SKID_STAGE_XFER_CNT_EN
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_cnt_rst", {16'd0, xfer_cnt}, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 65538; c++) begin
            d = 16'(c);
            tick();
        end
        in_valid = 1'b0;
        check("t6_cnt_wrap", {16'd0, xfer_cnt}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_cnt_clear", {16'd0, xfer_cnt}, 32'd0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/typed_skid_stage.md
Name: typed_skid_stage

Overview:
- Type-parameterized, 2-entry valid/ready skid buffer carrying a packed array of WIDTH elements of type DTYPE.
- Sits directly upstream of the type-parameterized inverting stage and feeds it registered, back-pressure-safe data.
- Uses the same parameter pair (width, DTYPE) as that stage so the two instantiate with identical overrides.
- Data is opaque: bits pass through unmodified, and no DTYPE fields are interpreted.

Parameters:
- width, 1, number of DTYPE elements per beat (>=1).
- DTYPE, logic, element type; any packed type (struct, typedef'd vector, packed array). Beat width W = width*$bits(DTYPE).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- d  input  DTYPE [width-1:0]  upstream beat data.
- out_valid  output  1  beat available to downstream.
- out_ready  input  1  downstream accepts the beat this cycle.
- q  output  DTYPE [width-1:0]  downstream beat data.

Behaviour:
Definitions:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.

Storage:
- main register: drives q.
- skid register: holds a beat when downstream stalls.
- Valid bits main_v and skid_v.

Outputs:
- out_valid = main_v; q = main data.
- in_ready = ~skid_v (registered; no combinational path from out_ready).

Reset (rst_n=0 at posedge):
- main_v=0, skid_v=0, main and skid data cleared to all-zero.
- Result: out_valid=0, in_ready=1, q=0.
- Reset overrides any simultaneous in_valid/out_ready; any beat in flight is discarded.

State machine (EMPTY: main_v=0; ONE: main_v=1,skid_v=0; FULL: both=1):
- EMPTY, in_fire -> ONE; main<=d.
- EMPTY, no in_fire -> EMPTY.
- ONE, in_fire & out_fire -> ONE; main<=d (back-to-back throughput, 1 beat/cycle).
- ONE, in_fire & ~out_fire -> FULL; skid<=d.
- ONE, ~in_fire & out_fire -> EMPTY.
- ONE, neither -> hold.
- FULL (in_ready=0, in_valid ignored), out_fire -> ONE; main<=skid.
- FULL, ~out_fire -> hold.
- skid_v=1 with main_v=0 is unreachable; assert it in simulation.

Timing and ordering:
- Latency: a beat accepted at posedge N is on q with out_valid=1 after posedge N (EMPTY case).
- Ordering is strict FIFO; no beat is dropped or duplicated.
- q and main data are stable while out_valid=1 and out_ready=0.
- in_valid may deassert without a transfer; there is no requirement that valid holds.

Optional Feature:
- Macro: TYPED_SKID_STAGE_XFER_CNT_EN.
- Defined: adds output port xfer_cnt [15:0].
  - Increments by 1 on every out_fire and wraps 16'hFFFF->16'h0000.
  - Cleared to 0 by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then width=4, DTYPE=logic[3:0]. In cycle 0, d=16'hA5C3 with in_valid=1, out_ready=1 -> after next posedge out_valid=1 and q=16'hA5C3. Return to out_valid=0 once input stops.
2. Stream 8 beats 16'h0001..16'h0008 with in_valid=1 and out_ready=1 every cycle -> q follows one cycle behind, in_ready stays 1, 8 outputs in order.
3. Backpressure: send 16'h1111 then 16'h2222 while out_ready=0 -> in_ready=0 after the 2nd beat, q holds 16'h1111. Send 16'h3333 while in_ready=0 -> ignored. Set out_ready=1 -> out 16'h1111, 16'h2222, then out_valid=0.
4. Reset mid-operation in FULL: assert rst_n=0 for one cycle -> out_valid=0, in_ready=1, q=16'h0000. A subsequent beat 16'hBEEF comes out alone.
5. Struct DTYPE (packed {logic[3:0] x; logic[1:5] y;}), width=2. d={9'h1F3,9'h0AA} -> q bit-exact equal. A downstream inverter on q yields {9'h00C,9'h155}.
6. With TYPED_SKID_STAGE_XFER_CNT_EN defined, 65537 transfers -> xfer_cnt=16'h0001. After reset -> xfer_cnt=0.
